// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl -- initiator side of the data-RAM interface.
//
// Accepts one load/store at a time from the MEM stage. It drives the RAM
// strobes as SETUP -> STROBE -> WAIT. Doubleword accesses run as two word
// beats, because the RAM's own doubleword mode delays reads and cannot
// write. Load data is formatted and returned with a one-cycle response.
//
// Optional build macro: DMEM_SIGN_EXT_EN
//   defined   : ReqSigned=1 sign-extends byte/halfword/word loads to 64 bits
//   undefined : ReqSigned is ignored and all loads are zero-extended
//
// Parameters
//   MEM_BYTES   : addressable bytes; accesses running past the end are rejected
//   WAIT_CYCLES : cycles Enable stays low after the strobe before data is sampled
//
// Ports
//   Clk, Reset           : clock, synchronous active-high reset
//   ReqValid/ReqReady    : request handshake (ready only in IDLE)
//   ReqWrite/ReqSize     : store flag, size (00 B, 01 H, 10 W, 11 D)
//   ReqSigned            : sign-extend loads (optional feature)
//   ReqAddr/ReqWData     : byte address, right-justified store data
//   RespValid/RespError  : one-cycle response pulse, rejection flag
//   RespRData            : formatted load data
//   MemEnable..MemDataIn : RAM strobes (big-endian byte memory)
//   MemDataOut           : RAM read data
//
// State table
//   state  | meaning
//   IDLE   | ready, waiting for a request
//   SETUP  | address/mode/data driven, Enable low
//   STROBE | Enable high for one cycle
//   WAIT   | Enable low for WAIT_CYCLES; read data sampled on last edge
//   RESP   | RespValid pulse, then back to IDLE

module dmem_access_ctrl #(
  parameter int unsigned MEM_BYTES   = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [63:0] ReqWData,
  output logic        RespValid,
  output logic        RespError,
  output logic [63:0] RespRData,
  output logic        MemEnable,
  output logic        MemReadWrite,
  output logic [1:0]  MemMode,
  output logic [31:0] MemAddress,
  output logic [31:0] MemDataIn,
  input  logic [31:0] MemDataOut
);

  localparam int unsigned WAIT_EFF = (WAIT_CYCLES == 0) ? 1 : WAIT_CYCLES;
  localparam int unsigned WCW      = (WAIT_EFF > 1) ? $clog2(WAIT_EFF) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(WAIT_EFF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state_q;
  logic            ready_q;
  logic            resp_valid_q;
  logic            resp_error_q;
  logic [63:0]     resp_rdata_q;
  logic            mem_en_q;
  logic            mem_rw_q;
  logic [1:0]      mem_mode_q;
  logic [31:0]     mem_addr_q;
  logic [31:0]     mem_din_q;
  logic            req_write_q;
  logic [1:0]      req_size_q;
  logic [31:0]     req_wdata_lo_q;
  logic            beat_q;
  logic [WCW-1:0]  wait_cnt_q;
  logic [31:0]     rdata_hi_q;

`ifdef DMEM_SIGN_EXT_EN
  logic            req_signed_q;
`else
  logic            unused_req_signed;
  assign unused_req_signed = ReqSigned;
`endif

  // Request qualification, evaluated on the incoming request.
  logic [3:0]  acc_bytes;
  logic [32:0] req_end;
  logic        req_misalign;
  logic        req_oob;
  logic        req_reject;
  logic [31:0] first_din;
  logic [63:0] ld_data;

  always_comb begin
    acc_bytes    = 4'd1 << ReqSize;
    // 33-bit sum so addresses near 2^32 cannot wrap into range.
    req_end      = {1'b0, ReqAddr} + {29'b0, acc_bytes};
    req_oob      = req_end > 33'(MEM_BYTES);
    req_misalign = 1'b0;
    first_din    = ReqWData[31:0];
    unique case (ReqSize)
      2'b00: begin
        req_misalign = 1'b0;
        first_din    = {24'b0, ReqWData[7:0]};
      end
      2'b01: begin
        req_misalign = ReqAddr[0];
        first_din    = {16'b0, ReqWData[15:0]};
      end
      2'b10: begin
        req_misalign = |ReqAddr[1:0];
        first_din    = ReqWData[31:0];
      end
      default: begin
        req_misalign = |ReqAddr[2:0];
        first_din    = ReqWData[63:32];
      end
    endcase
    req_reject = req_misalign | req_oob;
  end

  // Load formatting from the current RAM data; doubleword joins both beats.
  always_comb begin
    ld_data = {32'b0, MemDataOut};
    unique case (req_size_q)
      2'b00:   ld_data = {56'b0, MemDataOut[7:0]};
      2'b01:   ld_data = {48'b0, MemDataOut[15:0]};
      2'b10:   ld_data = {32'b0, MemDataOut};
      default: ld_data = {rdata_hi_q, MemDataOut};
    endcase
`ifdef DMEM_SIGN_EXT_EN
    if (req_signed_q) begin
      unique case (req_size_q)
        2'b00:   ld_data = {{56{MemDataOut[7]}},  MemDataOut[7:0]};
        2'b01:   ld_data = {{48{MemDataOut[15]}}, MemDataOut[15:0]};
        2'b10:   ld_data = {{32{MemDataOut[31]}}, MemDataOut};
        default: ld_data = {rdata_hi_q, MemDataOut};
      endcase
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      ready_q        <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_error_q   <= 1'b0;
      resp_rdata_q   <= '0;
      mem_en_q       <= 1'b0;
      mem_rw_q       <= 1'b0;
      mem_mode_q     <= 2'b00;
      mem_addr_q     <= '0;
      mem_din_q      <= '0;
      req_write_q    <= 1'b0;
      req_size_q     <= 2'b00;
      req_wdata_lo_q <= '0;
      beat_q         <= 1'b0;
      wait_cnt_q     <= '0;
      rdata_hi_q     <= '0;
`ifdef DMEM_SIGN_EXT_EN
      req_signed_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ReqValid) begin
            ready_q        <= 1'b0;
            req_write_q    <= ReqWrite;
            req_size_q     <= ReqSize;
            req_wdata_lo_q <= ReqWData[31:0];
            beat_q         <= 1'b0;
`ifdef DMEM_SIGN_EXT_EN
            req_signed_q   <= ReqSigned;
`endif
            if (req_reject) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q    <= S_SETUP;
              mem_addr_q <= ReqAddr;
              // Doubleword runs as word beats.
              mem_mode_q <= (ReqSize == 2'b11) ? 2'b10 : ReqSize;
              mem_rw_q   <= ReqWrite;
              mem_din_q  <= first_din;
            end
          end
        end
        S_SETUP: begin
          mem_en_q <= 1'b1;
          state_q  <= S_STROBE;
        end
        S_STROBE: begin
          mem_en_q   <= 1'b0;
          wait_cnt_q <= WAIT_LOAD;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_q != '0) begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end else if ((req_size_q == 2'b11) && !beat_q) begin
            beat_q     <= 1'b1;
            rdata_hi_q <= MemDataOut;
            mem_addr_q <= mem_addr_q + 32'd4;
            mem_din_q  <= req_wdata_lo_q;
            state_q    <= S_SETUP;
          end else begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b0;
            resp_rdata_q <= req_write_q ? 64'b0 : ld_data;
          end
        end
        S_RESP: begin
          resp_valid_q <= 1'b0;
          resp_error_q <= 1'b0;
          resp_rdata_q <= '0;
          mem_rw_q     <= 1'b0;
          ready_q      <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ReqReady     = ready_q;
  assign RespValid    = resp_valid_q;
  assign RespError    = resp_error_q;
  assign RespRData    = resp_rdata_q;
  assign MemEnable    = mem_en_q;
  assign MemReadWrite = mem_rw_q;
  assign MemMode      = mem_mode_q;
  assign MemAddress   = mem_addr_q;
  assign MemDataIn    = mem_din_q;

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Initiator side of the data-RAM interface (Enable / ReadWrite / Mode / Address / DataIn / DataOut, big-endian byte memory).
- Accepts one load/store request at a time from the pipeline MEM stage and sequences the RAM strobes.
- Splits doubleword accesses into two word beats, because the RAM's doubleword mode has internal delays on read and no write support.
- Formats read data and returns a single-cycle response.

Parameters:
MEM_BYTES, 256, addressable bytes; accesses extending past this limit are rejected.
WAIT_CYCLES, 1, cycles Enable stays low after the strobe before read data is sampled (minimum 1).

Ports:
Clk  input  1  clock, rising edge.
Reset  input  1  synchronous, active-high reset.
ReqValid  input  1  request present.
ReqReady  output  1  controller can accept a request.
ReqWrite  input  1  1=store, 0=load.
ReqSize  input  2  00 byte, 01 halfword, 10 word, 11 doubleword.
ReqSigned  input  1  sign-extend loads (used only with the optional feature).
ReqAddr  input  32  byte address.
ReqWData  input  64  store data, right-justified; doubleword uses all 64 bits.
RespValid  output  1  one-cycle response pulse.
RespError  output  1  valid with RespValid; access rejected.
RespRData  output  64  load data, valid with RespValid.
MemEnable  output  1  RAM Enable.
MemReadWrite  output  1  RAM ReadWrite (1=write).
MemMode  output  2  RAM Mode.
MemAddress  output  32  RAM Address.
MemDataIn  output  32  RAM DataIn.
MemDataOut  input  32  RAM DataOut.

Behaviour:
- One clock (Clk); synchronous active-high Reset.
- Reset values:
  - State=IDLE, ReqReady=1.
  - RespValid=0, RespError=0, RespRData=0.
  - MemEnable=0, MemReadWrite=0, MemMode=00, MemAddress=0, MemDataIn=0.
- FSM states: IDLE, SETUP, STROBE, WAIT, RESP.
- IDLE:
  - ReqReady=1.
  - On ReqValid, latch the request.
  - Valid request -> SETUP; rejected request -> RESP with RespError=1.
  - ReqReady=0 in every state except IDLE.
- Rejection (no memory access, MemEnable never asserted):
  - Misaligned: halfword addr[0]!=0; word addr[1:0]!=0; doubleword addr[2:0]!=0.
  - Out of range: ReqAddr+bytes > MEM_BYTES.
- SETUP (1 cycle):
  - Drive MemAddress, MemMode, MemReadWrite and MemDataIn; MemEnable=0.
  - Doubleword beats use MemMode=10.
- STROBE (1 cycle): MemEnable=1; all other Mem* outputs held.
- WAIT:
  - Lasts WAIT_CYCLES cycles with MemEnable=0 and all Mem* outputs held.
  - Loads sample MemDataOut on the edge ending the last WAIT cycle.
- After WAIT:
  - If doubleword beat 1 -> SETUP again with MemAddress+4.
  - Otherwise -> RESP.
- RESP (1 cycle):
  - RespValid=1 for exactly this cycle; no backpressure.
  - Next state IDLE; MemReadWrite returns to 0 in IDLE.
- Store data mapping:
  - Byte: ReqWData[7:0]. Halfword: [15:0]. Word: [31:0].
  - Doubleword: beat1 ReqWData[63:32] at Addr, beat2 ReqWData[31:0] at Addr+4.
- Load data mapping:
  - Byte: RespRData={56'b0, DataOut[7:0]}. Halfword: {48'b0, [15:0]}. Word: {32'b0, [31:0]}.
  - Doubleword: {beat1, beat2}.
  - Store responses and error responses return RespRData=0.
- Latency (accept edge = cycle T):
  - Single beat: RespValid at T+3+WAIT_CYCLES (T+4 at default).
  - Doubleword: T+1+2*(2+WAIT_CYCLES) (T+7 at default).
  - Error: T+1.
- MemEnable rises exactly once per beat; MemReadWrite never changes while MemEnable=1.
- Reset mid-operation:
  - Next edge forces IDLE and MemEnable=0; no RespValid is produced.
  - A store whose STROBE has already occurred stays in memory.
- Back-to-back requests: the earliest next accept is the cycle after RESP.

Optional Feature:
DMEM_SIGN_EXT_EN
- Defined: when ReqSigned=1, byte/halfword/word loads are sign-extended to 64 bits from bit 7/15/31 respectively.
- Undefined: ReqSigned is ignored; all loads are zero-extended.
- Doubleword loads and stores are unaffected in both cases.

Test Plan:
1. Word load, addr 0 (RAM bytes 0..7 = 01 23 45 67 89 AB CD EF) -> RespRData=0000_0000_0123_4567 at T+4; single MemEnable pulse at T+2; MemMode=10.
2. Doubleword load, addr 0 -> RespRData=0123_4567_89AB_CDEF at T+7; two Enable pulses with MemAddress 0 then 4, MemMode=10 both.
3. Doubleword store AAAA_BBBB_CCCC_DDDD to addr 8, then word loads at 8 and 12 -> 0000_0000_AAAA_BBBB and 0000_0000_CCCC_DDDD; byte load at 11 -> 0xBB.
4. Signed byte load, addr 4 -> FFFF_FFFF_FFFF_FF89 with DMEM_SIGN_EXT_EN, 0000_0000_0000_0089 without; signed halfword at 2 -> 0x4567 both builds.
5. Error cases -> RespError=1 at T+1, MemEnable never high: word at addr 2; doubleword at 4; word at 0x100. Word at 0xFC -> success.
6. Reset asserted during WAIT of a doubleword load -> next cycle MemEnable=0, ReqReady=1, no RespValid; a following word load at 4 returns 0x89AB_CDEF.
